// File: rtl/fft_stream_core.sv
// Streaming radix-2 DIT FFT: loads a frame in bit-reversed order, runs one
// time-shared butterfly per cycle, then streams the spectrum in natural order.
module fft_stream_core #(
   parameter  int unsigned N_POINTS = 16,
   parameter  int unsigned DATA_W   = 16,
   parameter  int unsigned TW_W     = 16,
   localparam int unsigned LOG2N    = $clog2(N_POINTS),
   localparam int unsigned OUT_W    = DATA_W + LOG2N
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_re,
   output logic [OUT_W-1:0]         out_im,
   output logic [LOG2N-1:0]         out_index,
   output logic                     out_last,
   output logic                     busy
);

   localparam int unsigned HALF   = N_POINTS / 2;
   localparam int unsigned BW     = LOG2N - 1;
   localparam int unsigned SW     = $clog2(LOG2N);
   localparam int unsigned PW     = OUT_W + TW_W + 1;
   localparam int          TW_MAX = (1 << (TW_W - 1)) - 1;
   localparam real         PI     = 3.14159265358979323846;

   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_OUTPUT} state_e;

   // Round-to-nearest quantiser for the elaboration-time twiddle table.
   function automatic int tw_quant(input real v);
      real s;
      int  q;
      s = v * (2.0 ** (TW_W - 1));
      q = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
      if (q > TW_MAX)  q = TW_MAX;
      if (q < -TW_MAX) q = -TW_MAX;
      return q;
   endfunction

   function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
      return r;
   endfunction

   logic signed [TW_W-1:0] tw_re [HALF];
   logic signed [TW_W-1:0] tw_im [HALF];

   for (genvar k = 0; k < HALF; k++) begin : g_tw
      localparam int C = tw_quant($cos(2.0 * PI * real'(k) / real'(N_POINTS)));
      localparam int S = tw_quant(-$sin(2.0 * PI * real'(k) / real'(N_POINTS)));
      assign tw_re[k] = TW_W'(C);
      assign tw_im[k] = TW_W'(S);
   end

   state_e                  state_q, state_d;
   logic [LOG2N-1:0]        cnt_q, cnt_d;
   logic [SW-1:0]           stage_q, stage_d;
   logic [BW-1:0]           bfly_q, bfly_d;
   logic                    in_ready_q, in_ready_d;
   logic                    busy_q, busy_d;
   logic                    out_valid_q, out_valid_d;
   logic [OUT_W-1:0]        out_re_q, out_re_d;
   logic [OUT_W-1:0]        out_im_q, out_im_d;
   logic [LOG2N-1:0]        out_index_q, out_index_d;
   logic                    out_last_q, out_last_d;
   logic                    load_we, bfly_we;

   logic signed [OUT_W-1:0] mem_re_q [N_POINTS];
   logic signed [OUT_W-1:0] mem_im_q [N_POINTS];

   // Butterfly addressing: a = bfly with a zero inserted at bit 'stage', b = a + span.
   logic [LOG2N-1:0]        bfly_ext, span, mask, addr_a, addr_b;
   logic [BW-1:0]           tw_k;
   assign bfly_ext = LOG2N'(bfly_q);
   assign span     = LOG2N'(1) << stage_q;
   assign mask     = span - LOG2N'(1);
   assign addr_a   = ((bfly_ext & ~mask) << 1) | (bfly_ext & mask);
   assign addr_b   = addr_a | span;
   assign tw_k     = BW'((bfly_ext & mask) << (SW'(BW) - stage_q));

   logic signed [OUT_W-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
   logic signed [TW_W-1:0]  w_re, w_im;
   logic signed [PW-1:0]    prod_re, prod_im;
   assign a_re    = mem_re_q[addr_a];
   assign a_im    = mem_im_q[addr_a];
   assign b_re    = mem_re_q[addr_b];
   assign b_im    = mem_im_q[addr_b];
   assign w_re    = tw_re[tw_k];
   assign w_im    = tw_im[tw_k];
   assign prod_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
   assign prod_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
   assign t_re    = OUT_W'(prod_re >>> (TW_W - 1));
   assign t_im    = OUT_W'(prod_im >>> (TW_W - 1));

   // Sample RAM: contents are don't-care after reset, so no reset branch.
   always_ff @(posedge clk) begin
      if (load_we) begin
         mem_re_q[bit_rev(cnt_q)] <= OUT_W'(in_data);
         mem_im_q[bit_rev(cnt_q)] <= '0;
      end else if (bfly_we) begin
         mem_re_q[addr_a] <= a_re + t_re;
         mem_im_q[addr_a] <= a_im + t_im;
         mem_re_q[addr_b] <= a_re - t_re;
         mem_im_q[addr_b] <= a_im - t_im;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_LOAD;
         cnt_q       <= '0;
         stage_q     <= '0;
         bfly_q      <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stage_q     <= stage_d;
         bfly_q      <= bfly_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stage_d     = stage_q;
      bfly_d      = bfly_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;
      out_valid_d = out_valid_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
      load_we     = 1'b0;
      bfly_we     = 1'b0;

      case (state_q)
         S_LOAD: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               load_we = 1'b1;
               cnt_d   = cnt_q + LOG2N'(1);
               if (cnt_q == LOG2N'(N_POINTS - 1)) begin
                  state_d    = S_COMPUTE;
                  cnt_d      = '0;
                  in_ready_d = 1'b0;
                  busy_d     = 1'b1;
               end
            end
         end
         S_COMPUTE: begin
            bfly_we = 1'b1;
            bfly_d  = bfly_q + BW'(1);
            if (bfly_q == BW'(HALF - 1)) begin
               bfly_d  = '0;
               stage_d = stage_q + SW'(1);
               if (stage_q == SW'(LOG2N - 1)) begin
                  // Bin 0 is never touched by the final butterfly, so it is safe to read now.
                  stage_d     = '0;
                  state_d     = S_OUTPUT;
                  busy_d      = 1'b0;
                  out_valid_d = 1'b1;
                  out_index_d = '0;
                  out_re_d    = mem_re_q[0];
                  out_im_d    = mem_im_q[0];
                  out_last_d  = 1'b0;
               end
            end
         end
         S_OUTPUT: begin
            if (out_valid_q && out_ready) begin
               if (out_last_q) begin
                  state_d     = S_LOAD;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  in_ready_d  = 1'b1;
               end else begin
                  out_index_d = out_index_q + LOG2N'(1);
                  out_re_d    = mem_re_q[out_index_d];
                  out_im_d    = mem_im_q[out_index_d];
                  out_last_d  = (out_index_d == LOG2N'(N_POINTS - 1));
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;

endmodule
